conv_param: RTL and testbench

Parametrised 1-D convolution engine with runtime-loadable filter, P-way output parallelism and optional ReLU. It is the generalised successor of the fixed-size conv_N_M_T_P blocks. It accepts an M-tap filter on a weight stream and N-sample input vectors on a data stream. For each vector it emits N-M+1 saturated results, in groups of P, over a valid/ready stream. It sits between the input FIFO and the activation/pooling stage of the CNN datapath.

---
 rtl/conv_param.sv | 191 +++++++++++++++++++
 tb/tb_conv_param.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_param.sv
`default_nettype none
// ============================================================================
// Module : conv_param
// Brief  : 1-D convolution engine, runtime filter, P-lane output, optional ReLU
// Rev    : 1.0
// ============================================================================
module conv_param #(
  parameter int N    = 128,
  parameter int M    = 8,
  parameter int T    = 16,
  parameter int P    = 1,
  parameter int RELU = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [T-1:0]   x_data,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [T-1:0]   w_data,
  input  logic           w_valid,
  output logic           w_ready,
  output logic [P*T-1:0] y_data,
  output logic           y_valid,
  input  logic           y_ready
);

  localparam int c_NOUT = N - M + 1;
  localparam int c_G    = c_NOUT / P;
  localparam int c_AW   = 2*T + $clog2(M);
  localparam int c_XW   = $clog2(N);
  localparam int c_KW   = $clog2(M);
  localparam int c_GW   = (c_G > 1) ? $clog2(c_G) : 1;

  localparam logic signed [c_AW-1:0] c_SAT_MAX = {{(c_AW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [c_AW-1:0] c_SAT_MIN = {{(c_AW-T+1){1'b1}}, {(T-1){1'b0}}};
  localparam logic signed [T-1:0]    c_MAX_T   = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0]    c_MIN_T   = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [2:0] {
    S_LOAD_W  = 3'd0,
    S_LOAD_X  = 3'd1,
    S_COMPUTE = 3'd2,
    S_SAT     = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t                 r_state;
  logic signed [T-1:0]    r_f [M];
  logic signed [T-1:0]    r_x [N];
  logic [c_KW-1:0]        r_wcnt;
  logic [c_KW-1:0]        r_k;
  logic [c_XW-1:0]        r_xcnt;
  logic [c_GW-1:0]        r_g;
  logic signed [c_AW-1:0] r_acc [P];
  logic [P*T-1:0]         r_y;
  logic                   r_yvalid;

  logic                   w_reload;
  logic signed [T-1:0]    w_tap;
  logic [P*2*T-1:0]       w_prod_all;
  logic [P*T-1:0]         w_ysat_all;

  // A weight word arriving before the first sample of a vector restarts the filter load.
  assign w_reload = (r_state == S_LOAD_X) && (r_xcnt == '0) && w_valid;
  assign x_ready  = (r_state == S_LOAD_X) && !w_reload;
  assign w_ready  = (r_state == S_LOAD_W);
  assign y_valid  = r_yvalid;
  assign y_data   = r_y;
  assign w_tap    = r_f[r_k];

  genvar gp;
  generate
    for (gp = 0; gp < P; gp++) begin : g_lane
      logic [c_XW-1:0]     w_idx;
      logic signed [2*T-1:0] w_prod;
      logic signed [T-1:0] w_sat;

      assign w_idx  = c_XW'(int'(r_g) * P + int'(r_k) + gp);
      assign w_prod = (2*T)'(w_tap) * (2*T)'(r_x[w_idx]);

      always_comb begin
        w_sat = r_acc[gp][T-1:0];
        if (r_acc[gp] > c_SAT_MAX) begin
          w_sat = c_MAX_T;
        end else if (r_acc[gp] < c_SAT_MIN) begin
          w_sat = c_MIN_T;
        end
        if ((RELU != 0) && w_sat[T-1]) begin
          w_sat = '0;
        end
      end

      assign w_prod_all[gp*2*T +: 2*T] = w_prod;
      assign w_ysat_all[gp*T +: T]     = w_sat;
    end
  endgenerate

  // Filter and sample storage carry no reset; contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (!reset && w_ready && w_valid) begin
      r_f[r_wcnt] <= w_data;
    end
    if (!reset && x_ready && x_valid) begin
      r_x[r_xcnt] <= x_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_LOAD_W;
      r_wcnt   <= '0;
      r_xcnt   <= '0;
      r_k      <= '0;
      r_g      <= '0;
      r_y      <= '0;
      r_yvalid <= 1'b0;
      for (int p = 0; p < P; p++) begin
        r_acc[p] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD_W: begin
          if (w_valid) begin
            if (r_wcnt == c_KW'(M-1)) begin
              r_wcnt  <= '0;
              r_xcnt  <= '0;
              r_state <= S_LOAD_X;
            end else begin
              r_wcnt <= r_wcnt + c_KW'(1);
            end
          end
        end
        S_LOAD_X: begin
          if (w_reload) begin
            r_wcnt  <= '0;
            r_state <= S_LOAD_W;
          end else if (x_valid) begin
            if (r_xcnt == c_XW'(N-1)) begin
              r_xcnt  <= '0;
              r_g     <= '0;
              r_k     <= '0;
              r_state <= S_COMPUTE;
              for (int p = 0; p < P; p++) begin
                r_acc[p] <= '0;
              end
            end else begin
              r_xcnt <= r_xcnt + c_XW'(1);
            end
          end
        end
        S_COMPUTE: begin
          for (int p = 0; p < P; p++) begin
            r_acc[p] <= r_acc[p] + c_AW'(signed'(w_prod_all[p*2*T +: 2*T]));
          end
          if (r_k == c_KW'(M-1)) begin
            r_k     <= '0;
            r_state <= S_SAT;
          end else begin
            r_k <= r_k + c_KW'(1);
          end
        end
        S_SAT: begin
          r_y      <= w_ysat_all;
          r_yvalid <= 1'b1;
          r_state  <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (y_ready) begin
            r_yvalid <= 1'b0;
            if (r_g == c_GW'(c_G-1)) begin
              r_xcnt  <= '0;
              r_state <= S_LOAD_X;
            end else begin
              r_g     <= r_g + c_GW'(1);
              r_k     <= '0;
              r_state <= S_COMPUTE;
              for (int p = 0; p < P; p++) begin
                r_acc[p] <= '0;
              end
            end
          end
        end
        default: begin
          r_state <= S_LOAD_W;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_param.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_param
// Brief  : Self-checking bench; DUT A (P=1, ReLU) and DUT B (P=11, no ReLU)
// Rev    : 1.0
// ============================================================================
module tb_conv_param;

  localparam int N  = 128;
  localparam int M  = 8;
  localparam int T  = 16;
  localparam int PB = 11;
  localparam int NOUT = N - M + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [T-1:0]  x_data, w_data;
  logic          x_valid, w_valid;
  logic          x_ready_a, w_ready_a, y_valid_a, y_ready_a;
  logic          x_ready_b, w_ready_b, y_valid_b, y_ready_b;
  logic [T-1:0]  y_data_a;
  logic [PB*T-1:0] y_data_b;

  int checks = 0;
  int errors = 0;
  bit col_on = 1'b0;
  bit thr    = 1'b0;

  logic [T-1:0] taps [M];
  logic [T-1:0] xbuf [N];
  logic [T-1:0] qa [$];
  logic [T-1:0] qb [$];

  typedef struct {
    logic [T-1:0] tap;
    logic [T-1:0] xv;
    logic [T-1:0] exp_relu;
    logic [T-1:0] exp_raw;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  conv_param #(.N(N), .M(M), .T(T), .P(1), .RELU(1)) u_a (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_a),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready_a),
    .y_data(y_data_a), .y_valid(y_valid_a), .y_ready(y_ready_a)
  );

  conv_param #(.N(N), .M(M), .T(T), .P(PB), .RELU(0)) u_b (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_b),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready_b),
    .y_data(y_data_b), .y_valid(y_valid_b), .y_ready(y_ready_b)
  );

  task automatic chk16(input string nm, input logic [T-1:0] act, input logic [T-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout %s got expired wait expected event", nm);
  endtask

  function automatic logic [T-1:0] ref_y(input int i, input bit relu);
    longint s = 0;
    for (int k = 0; k < M; k++) begin
      s += longint'($signed(taps[k])) * longint'($signed(xbuf[i+k]));
    end
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[T-1:0];
  endfunction

  // Output collectors: one entry popped per lane per handshake.
  initial begin
    y_ready_a = 1'b0;
    forever begin
      @(negedge clk);
      if (col_on) begin
        y_ready_a = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        if (y_valid_a && y_ready_a) begin
          if (qa.size() == 0) timeout("y_a_unexpected");
          else chk16("y_a", y_data_a, qa.pop_front());
        end
      end else begin
        y_ready_a = 1'b0;
      end
    end
  end

  initial begin
    y_ready_b = 1'b0;
    forever begin
      @(negedge clk);
      if (col_on) begin
        y_ready_b = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        if (y_valid_b && y_ready_b) begin
          for (int p = 0; p < PB; p++) begin
            if (qb.size() == 0) timeout("y_b_unexpected");
            else chk16("y_b_lane", y_data_b[p*T +: T], qb.pop_front());
          end
        end
      end else begin
        y_ready_b = 1'b0;
      end
    end
  end

  task automatic load_w(input bit reload);
    int wt;
    if (reload) begin
      wt = 0;
      @(negedge clk);
      while (!(x_ready_a && x_ready_b) && wt < 20000) begin
        @(negedge clk);
        wt++;
      end
      if (wt >= 20000) timeout("idle_before_reload");
      w_data  = taps[0];
      w_valid = 1'b1;
      #1;
      chk1("reload_x_ready_a", x_ready_a, 1'b0);
      chk1("reload_x_ready_b", x_ready_b, 1'b0);
      @(posedge clk);
    end
    for (int j = 0; j < M; j++) begin
      @(negedge clk);
      w_data  = taps[j];
      w_valid = 1'b1;
      wt = 0;
      while (!(w_ready_a && w_ready_b) && wt < 100) begin
        @(negedge clk);
        wt++;
      end
      if (wt >= 100) timeout("w_ready");
      @(posedge clk);
    end
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic send_x(input bit throttle);
    int  i = 0;
    int  wt = 0;
    int  la = -1;
    int  lb = -1;
    bit  hs;
    while (i < N && wt < 30000) begin
      @(negedge clk);
      x_data  = xbuf[i];
      x_valid = x_ready_a && x_ready_b && (!throttle || ($urandom_range(0, 1) == 1));
      hs      = x_valid;
      @(posedge clk);
      if (hs) i++;
      wt++;
    end
    if (i < N) timeout("x_stream");
    @(negedge clk);
    x_valid = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      if (la < 0 && y_valid_a) la = c;
      if (lb < 0 && y_valid_b) lb = c;
      if (la >= 0 && lb >= 0) break;
      @(posedge clk);
      @(negedge clk);
    end
    chkint("latency_a", la, M + 1);
    chkint("latency_b", lb, M + 1);
  endtask

  task automatic drain();
    int wt = 0;
    while ((qa.size() != 0 || qb.size() != 0) && wt < 20000) begin
      @(negedge clk);
      wt++;
    end
    if (wt >= 20000) timeout("drain");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h0001, 16'h0003, 16'h0018, 16'h0018};
    tbl[1]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[2]  = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFF8};
    tbl[3]  = '{16'h0002, 16'hFFFF, 16'h0000, 16'hFFF0};
    tbl[4]  = '{16'h0100, 16'h0010, 16'h7FFF, 16'h7FFF};
    tbl[5]  = '{16'h0010, 16'h0010, 16'h0800, 16'h0800};
    tbl[6]  = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
    tbl[7]  = '{16'h8000, 16'h7FFF, 16'h0000, 16'h8000};
    tbl[8]  = '{16'hFFFF, 16'h1000, 16'h0000, 16'h8000};
    tbl[9]  = '{16'h0001, 16'h0FFF, 16'h7FF8, 16'h7FF8};
    tbl[10] = '{16'hFFFF, 16'hF001, 16'h7FF8, 16'h7FF8};

    reset   = 1'b1;
    x_valid = 1'b0;
    w_valid = 1'b0;
    x_data  = '0;
    w_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk1("rst_y_valid_a", y_valid_a, 1'b0);
    chk1("rst_x_ready_a", x_ready_a, 1'b0);
    chk1("rst_w_ready_a", w_ready_a, 1'b1);
    chk1("rst_y_valid_b", y_valid_b, 1'b0);
    chk1("rst_x_ready_b", x_ready_b, 1'b0);
    chk1("rst_w_ready_b", w_ready_b, 1'b1);

    // Samples offered before any filter is loaded must be refused.
    x_data  = 16'h0055;
    x_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("nofilter_x_ready_a", x_ready_a, 1'b0);
      chk1("nofilter_x_ready_b", x_ready_b, 1'b0);
    end
    x_valid = 1'b0;
    col_on  = 1'b1;

    for (int k = 0; k < M; k++) taps[k] = 16'd1;
    for (int i = 0; i < N; i++) xbuf[i] = 16'(i);
    load_w(1'b0);
    for (int i = 0; i < NOUT; i++) begin
      qa.push_back(16'(8*i + 28));
      qb.push_back(16'(8*i + 28));
    end
    send_x(1'b0);

    for (int k = 0; k < M; k++) taps[k] = 16'd2;
    load_w(1'b1);
    for (int i = 0; i < NOUT; i++) begin
      qa.push_back(16'(2*(8*i + 28)));
      qb.push_back(16'(2*(8*i + 28)));
    end
    send_x(1'b0);

    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < M; k++) taps[k] = tbl[r].tap;
      load_w(1'b1);
      for (int i = 0; i < N; i++) xbuf[i] = tbl[r].xv;
      for (int i = 0; i < NOUT; i++) begin
        qa.push_back(tbl[r].exp_relu);
        qb.push_back(tbl[r].exp_raw);
      end
      send_x(1'b0);
    end

    for (int k = 0; k < M; k++) begin
      int t = int'($urandom_range(0, 31)) - 16;
      taps[k] = t[T-1:0];
    end
    load_w(1'b1);
    thr = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < N; i++) begin
        int t = int'($urandom_range(0, 2047)) - 1024;
        xbuf[i] = t[T-1:0];
      end
      for (int i = 0; i < NOUT; i++) begin
        qa.push_back(ref_y(i, 1'b1));
        qb.push_back(ref_y(i, 1'b0));
      end
      send_x(1'b1);
    end
    drain();
    thr = 1'b0;

    // Stall both outputs, then reset while results are pending.
    for (int k = 0; k < M; k++) taps[k] = 16'd1;
    load_w(1'b1);
    col_on = 1'b0;
    for (int i = 0; i < N; i++) xbuf[i] = 16'(i);
    send_x(1'b0);
    repeat (2) @(negedge clk);
    chk1("stall_y_valid_b", y_valid_b, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk1("midrst_y_valid_a", y_valid_a, 1'b0);
    chk1("midrst_y_valid_b", y_valid_b, 1'b0);
    chk1("midrst_w_ready_b", w_ready_b, 1'b1);
    chk1("midrst_x_ready_b", x_ready_b, 1'b0);

    col_on = 1'b1;
    for (int k = 0; k < M; k++) taps[k] = 16'd3;
    load_w(1'b0);
    for (int i = 0; i < NOUT; i++) begin
      qa.push_back(16'(3*(8*i + 28)));
      qb.push_back(16'(3*(8*i + 28)));
    end
    send_x(1'b0);
    drain();
    repeat (4) @(negedge clk);
    chk1("end_y_valid_a", y_valid_a, 1'b0);
    chk1("end_y_valid_b", y_valid_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
